// File: rtl/adc_sound_monitor.sv
// Serial ADC capture (16-clk frame, 8-bit sample) with windowed peak-to-peak tone detect.
// Latency: sample_valid 1 clk after cs_n rises; window_done 1 clk after the last sample_valid of a window.
// No backpressure; define DETECT_HOLD_EN for a sticky detect with a detect_clr input.
module adc_sound_monitor #(
  parameter int CLK_DIV   = 8,
  parameter int WINDOW    = 256,
  parameter int THRESHOLD = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
`ifdef DETECT_HOLD_EN
  input  logic       detect_clr,
`endif
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_sdata,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [7:0] peak_to_peak,
  output logic       window_done,
  output logic       detect
);

  localparam int QUIET_CLKS = 4 * CLK_DIV;

  typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

  state_t      state, state_nxt;
  logic        start_conv;
  logic [7:0]  div_cnt;
  logic [4:0]  edge_cnt;
  logic [9:0]  quiet_cnt;
  logic        rise_tick;
  logic [3:0]  rise_idx;
  logic [7:0]  shift;
  logic        div_hit;
  logic        quiet_done;

  logic [15:0] win_cnt;
  logic [7:0]  win_min, win_max;
  logic [7:0]  nxt_min, nxt_max, win_diff;
  logic        win_hit;

  assign div_hit    = (state == CONVERT) && !adc_cs_n && (div_cnt == 8'(CLK_DIV - 1));
  assign quiet_done = (quiet_cnt == 10'(QUIET_CLKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_conv = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = CONVERT;
          start_conv = 1'b1;
        end
      end
      CONVERT: begin
        if (sample_valid) state_nxt = QUIET;
      end
      QUIET: begin
        if (quiet_done) begin
          if (enable) begin
            state_nxt  = CONVERT;
            start_conv = 1'b1;
          end else begin
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge 31 is the 16th rise: cs_n releases on the same clk edge, so no further toggles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      div_cnt      <= '0;
      edge_cnt     <= '0;
      quiet_cnt    <= '0;
      rise_tick    <= 1'b0;
      rise_idx     <= '0;
      shift        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      rise_tick    <= 1'b0;
      sample_valid <= 1'b0;
      if (start_conv) begin
        adc_cs_n <= 1'b0;
        div_cnt  <= '0;
        edge_cnt <= '0;
      end else if (div_hit) begin
        div_cnt  <= '0;
        adc_sclk <= ~adc_sclk;
        edge_cnt <= edge_cnt + 5'd1;
        if (!adc_sclk) begin
          rise_tick <= 1'b1;
          rise_idx  <= edge_cnt[4:1];
        end
        if (edge_cnt == 5'd31) adc_cs_n <= 1'b1;
      end else if ((state == CONVERT) && !adc_cs_n) begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (rise_tick) begin
        if ((rise_idx >= 4'd3) && (rise_idx <= 4'd10)) shift <= {shift[6:0], adc_sdata};
        if (rise_idx == 4'd15) begin
          sample       <= shift;
          sample_valid <= 1'b1;
        end
      end

      quiet_cnt <= (state == QUIET) ? quiet_cnt + 10'd1 : 10'd0;
    end
  end

  always_comb begin
    nxt_min  = (sample < win_min) ? sample : win_min;
    nxt_max  = (sample > win_max) ? sample : win_max;
    win_diff = nxt_max - nxt_min;
    win_hit  = (win_diff >= 8'(THRESHOLD));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt      <= '0;
      win_min      <= 8'hFF;
      win_max      <= 8'h00;
      peak_to_peak <= '0;
      window_done  <= 1'b0;
      detect       <= 1'b0;
    end else begin
      window_done <= 1'b0;
      if (sample_valid) begin
        if (win_cnt == 16'(WINDOW - 1)) begin
          peak_to_peak <= win_diff;
          window_done  <= 1'b1;
          win_cnt      <= '0;
          win_min      <= 8'hFF;
          win_max      <= 8'h00;
`ifdef DETECT_HOLD_EN
          if (win_hit) detect <= 1'b1;
`else
          detect <= win_hit;
`endif
        end else begin
          win_cnt <= win_cnt + 16'd1;
          win_min <= nxt_min;
          win_max <= nxt_max;
        end
      end
`ifdef DETECT_HOLD_EN
      // Clear wins over a same-cycle set; the next loud window sets it again.
      if (detect_clr) detect <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_adc_sound_monitor.sv
// Bench for adc_sound_monitor: ADC serial model feeding a sample/window scoreboard plus frame timing checks.
module tb_adc_sound_monitor;

  localparam int CLK_DIV   = 8;
  localparam int WINDOW    = 4;
  localparam int THRESHOLD = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       adc_sdata = 1'b0;
  logic       adc_cs_n, adc_sclk, sample_valid, window_done, detect;
  logic [7:0] sample, peak_to_peak;
`ifdef DETECT_HOLD_EN
  logic       detect_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  adc_sound_monitor #(
    .CLK_DIV(CLK_DIV),
    .WINDOW(WINDOW),
    .THRESHOLD(THRESHOLD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
`ifdef DETECT_HOLD_EN
    .detect_clr(detect_clr),
`endif
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_sdata(adc_sdata),
    .sample(sample),
    .sample_valid(sample_valid),
    .peak_to_peak(peak_to_peak),
    .window_done(window_done),
    .detect(detect)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_sv = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus samples, expected samples and expected window results.
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] p2p_q[$];
  logic       det_q[$];

  // ADC model: new frame on cs_n fall, each bit driven after an SCLK fall.
  logic [15:0] frame = '0;
  int          fidx = 0;

  always @(negedge adc_cs_n) begin
    logic [7:0] s;
    if (stim_q.size() > 0) s = stim_q.pop_front();
    else                   s = 8'($urandom_range(0, 255));
    frame = {3'b000, s, 5'b11111};
    exp_q.push_back(s);
    fidx = 0;
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && fidx < 16) begin
      adc_sdata = frame[15 - fidx];
      fidx++;
    end
  end

  // Reference window model.
  int         m_cnt = 0;
  logic [7:0] m_min = 8'hFF;
  logic [7:0] m_max = 8'h00;
  logic       m_sticky = 1'b0;

  task automatic model_reset();
    m_cnt = 0;
    m_min = 8'hFF;
    m_max = 8'h00;
    m_sticky = 1'b0;
  endtask

  task automatic model_add(input logic [7:0] s);
    logic [7:0] d;
    m_cnt++;
    if (s < m_min) m_min = s;
    if (s > m_max) m_max = s;
    if (m_cnt == WINDOW) begin
      d = m_max - m_min;
      p2p_q.push_back(d);
`ifdef DETECT_HOLD_EN
      if (d >= THRESHOLD) m_sticky = 1'b1;
      det_q.push_back(m_sticky);
`else
      det_q.push_back(d >= THRESHOLD);
`endif
      m_cnt = 0;
      m_min = 8'hFF;
      m_max = 8'h00;
    end
  endtask

  // Monitor: frame event timestamps plus scoreboard pops.
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b1;
  int   mon_nfall = 0;
  int   mon_nrise = 0;
  int   cs_fall_q[$];
  int   cs_rise_q[$];
  int   sclk_first_q[$];
  int   nfall_q[$];
  int   nrise_q[$];
  int   sv_q[$];

  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n) begin
      if (prev_cs && !adc_cs_n) begin
        cs_fall_q.push_back(cyc);
        mon_nfall = 0;
        mon_nrise = 0;
      end
      if (prev_sclk && !adc_sclk) begin
        if (mon_nfall == 0) sclk_first_q.push_back(cyc);
        mon_nfall++;
      end
      if (!prev_sclk && adc_sclk) mon_nrise++;
      if (!prev_cs && adc_cs_n) begin
        cs_rise_q.push_back(cyc);
        nfall_q.push_back(mon_nfall);
        nrise_q.push_back(mon_nrise);
      end
      if (sample_valid) begin
        sv_q.push_back(cyc);
        n_sv++;
        if (exp_q.size() == 0) chk("sv_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sample", sample, e);
          model_add(e);
        end
      end
      if (window_done) begin
        if (p2p_q.size() == 0) chk("wd_unexpected", 1, 0);
        else begin
          chk("p2p", peak_to_peak, p2p_q.pop_front());
          chk("detect", detect, det_q.pop_front());
        end
      end
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic wait_sv(input int n);
    int tgt = n_sv + n;
    int lim = cyc + n * 400 + 100;
    while (n_sv < tgt && cyc < lim) @(negedge clk);
    if (n_sv < tgt) chk("sv_timeout", n_sv, tgt);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bit(input int min_falls);
    int nf  = cs_fall_q.size();
    int lim = cyc + 600;
    while (!(cs_fall_q.size() > nf && mon_nfall >= min_falls) && cyc < lim) @(negedge clk);
    if (!(cs_fall_q.size() > nf && mon_nfall >= min_falls)) chk("bit_timeout", mon_nfall, min_falls);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t_en;
    int nf;

    repeat (5) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_p2p", peak_to_peak, 0);
    chk("rst_wd", window_done, 0);
    chk("rst_detect", detect, 0);

    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_cs_n", adc_cs_n, 1);

    foreach (stim_q[i]) stim_q.delete(i);
    stim_q = '{8'h40, 8'h80, 8'h60, 8'h70,
               8'h50, 8'h51, 8'h52, 8'h53,
               8'h00, 8'hFF, 8'h00, 8'hFF,
               8'h10, 8'h10, 8'h10, 8'h10,
               8'hA5};

    t_en = cyc;
    enable = 1'b1;

    // Window 1 also contains the first two frames used for timing.
    wait_sv(4);
    chk("w1_p2p", peak_to_peak, 8'h40);
    chk("w1_detect", detect, 1);
    chk("t_cs_latency", cs_fall_q[0] - t_en, 1);
    chk("t_first_fall", sclk_first_q[0] - cs_fall_q[0], CLK_DIV);
    chk("t_cs_rise", cs_rise_q[0] - cs_fall_q[0], 32 * CLK_DIV);
    chk("n_falls", nfall_q[0], 16);
    chk("n_rises", nrise_q[0], 16);
    chk("t_sv", sv_q[0] - cs_rise_q[0], 1);
    chk("t_period", cs_fall_q[1] - cs_fall_q[0], 36 * CLK_DIV + 2);

    wait_sv(4);
    chk("w2_p2p", peak_to_peak, 8'h03);
    chk("w2_detect", detect, 0);

    wait_sv(4);
    chk("w3_p2p", peak_to_peak, 8'hFF);
    chk("w3_detect", detect, 1);

    wait_sv(4);
    chk("w4_p2p", peak_to_peak, 8'h00);
`ifdef DETECT_HOLD_EN
    chk("w4_detect_held", detect, 1);
    @(negedge clk);
    detect_clr = 1'b1;
    @(negedge clk);
    detect_clr = 1'b0;
    m_sticky = 1'b0;
    chk("detect_cleared", detect, 0);
`else
    chk("w4_detect", detect, 0);
`endif

    wait_sv(1);
    chk("a5_sample", sample, 8'hA5);

    // Drop enable during bit 6 of a frame: frame must finish, then idle.
    wait_bit(7);
    enable = 1'b0;
    wait_sv(1);
    nf = cs_fall_q.size();
    repeat (40) @(negedge clk);
    chk("drop_cs_n", adc_cs_n, 1);
    chk("drop_sclk", adc_sclk, 1);
    chk("drop_no_frame", cs_fall_q.size(), nf);

    t_en = cyc;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("reen_frames", cs_fall_q.size(), nf + 1);
    chk("reen_latency", cs_fall_q[$] - t_en, 1);
    wait_sv(6);

    // Reset in the middle of a frame.
    wait_bit(5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cs_n", adc_cs_n, 1);
    chk("arst_sclk", adc_sclk, 1);
    chk("arst_sample", sample, 0);
    chk("arst_p2p", peak_to_peak, 0);
    chk("arst_detect", detect, 0);
    exp_q.delete();
    p2p_q.delete();
    det_q.delete();
    stim_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    stim_q.push_back(8'h3C);
    reset_n = 1'b1;
    wait_sv(1);
    chk("post_rst_sample", sample, 8'h3C);
    wait_sv(4);

    enable = 1'b0;
    repeat (400) @(negedge clk);
    chk("end_cs_n", adc_cs_n, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
